// File: rtl/reg_bank_pkg.sv
// Shared sizing and op encoding for the 8x16 operand register bank.
// Imported by the bank top level and its per-entry cell.
package reg_bank_pkg;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_INC  = 2'b10,
        OP_CLR  = 2'b11
    } reg_op_t;

endpackage

// File: rtl/reg16_cell.sv
// One bank entry with its sticky increment-overflow flag.
// The op is only decoded when the entry is selected, so X on idle inputs is harmless.
module reg16_cell
    import reg_bank_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sel,
    input  logic [1:0]   op,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] q,
    output logic         ovf
);

    logic [W-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;
    logic [W:0]   inc_sum;

    assign inc_sum = {1'b0, q_q} + {{W{1'b0}}, 1'b1};

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (sel) begin
            case (op)
                OP_LOAD: q_d = wr_data;
                OP_INC: begin
                    q_d = inc_sum[W-1:0];
                    if (inc_sum[W]) ovf_d = 1'b1;
                end
                OP_CLR: begin
                    q_d   = '0;
                    ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/register_bank8x16.sv
// Eight-entry 16-bit register bank feeding the operand mux inputs m0..m7.
// Single write port; all entries and status are flop outputs only.
module register_bank8x16
    import reg_bank_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  r0,
    output logic [WIDTH-1:0]  r1,
    output logic [WIDTH-1:0]  r2,
    output logic [WIDTH-1:0]  r3,
    output logic [WIDTH-1:0]  r4,
    output logic [WIDTH-1:0]  r5,
    output logic [WIDTH-1:0]  r6,
    output logic [WIDTH-1:0]  r7,
    output logic [DEPTH-1:0]  ovf,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] last_addr
);

    logic [WIDTH-1:0]  q [DEPTH];
    logic [DEPTH-1:0]  sel;
    logic              accept;
    logic              wr_ack_q, wr_ack_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    assign accept = wr_en && (op != OP_NOP);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign sel[i] = wr_en && (wr_addr == ADDR_W'(i));

        reg16_cell #(.W(WIDTH)) u_cell (
            .clock   (clock),
            .reset   (reset),
            .sel     (sel[i]),
            .op      (op),
            .wr_data (wr_data),
            .q       (q[i]),
            .ovf     (ovf[i])
        );
    end

    always_comb begin
        wr_ack_d    = accept;
        last_addr_d = last_addr_q;
        if (accept) last_addr_d = wr_addr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ack_q    <= 1'b0;
            last_addr_q <= '0;
        end else begin
            wr_ack_q    <= wr_ack_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign wr_ack    = wr_ack_q;
    assign last_addr = last_addr_q;

    assign r0 = q[0];
    assign r1 = q[1];
    assign r2 = q[2];
    assign r3 = q[3];
    assign r4 = q[4];
    assign r5 = q[5];
    assign r6 = q[6];
    assign r7 = q[7];

endmodule

// File: tb/tb_register_bank8x16.sv
// Bench for register_bank8x16: directed cases then random ops against a
// simple array model, with entries also read back through an 8-to-1 mux.
module tb_register_bank8x16;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [1:0]  op;
    logic [15:0] wr_data;
    logic [15:0] r [8];
    logic [7:0]  ovf;
    logic        wr_ack;
    logic [2:0]  last_addr;

    logic [2:0]  msel;
    logic [15:0] mux_out;

    int checks;
    int errors;

    // reference model
    int unsigned m_val [8];
    bit          m_ovf [8];
    bit          m_ack;
    int unsigned m_last;

    register_bank8x16 dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .op        (op),
        .wr_data   (wr_data),
        .r0        (r[0]),
        .r1        (r[1]),
        .r2        (r[2]),
        .r3        (r[3]),
        .r4        (r[4]),
        .r5        (r[5]),
        .r6        (r[6]),
        .r7        (r[7]),
        .ovf       (ovf),
        .wr_ack    (wr_ack),
        .last_addr (last_addr)
    );

    always_comb mux_out = r[msel];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_val[i] = 0;
            m_ovf[i] = 0;
        end
        m_ack  = 0;
        m_last = 0;
    endtask

    task automatic model_op(input bit en, input int unsigned a,
                            input int unsigned o, input int unsigned d);
        if (en && o != 0) begin
            if (o == 1) begin
                m_val[a] = d;
            end else if (o == 2) begin
                if (m_val[a] == 65535) m_ovf[a] = 1;
                m_val[a] = (m_val[a] + 1) % 65536;
            end else begin
                m_val[a] = 0;
                m_ovf[a] = 0;
            end
            m_ack  = 1;
            m_last = a;
        end else begin
            m_ack = 0;
        end
    endtask

    task automatic check_all(input string ctx);
        logic [7:0] exp_ovf;
        exp_ovf = '0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s r%0d", ctx, i), {16'h0, r[i]}, m_val[i]);
            exp_ovf[i] = m_ovf[i];
        end
        chk({ctx, " ovf"}, {24'h0, ovf}, {24'h0, exp_ovf});
        chk({ctx, " wr_ack"}, {31'h0, wr_ack}, {31'h0, m_ack});
        chk({ctx, " last_addr"}, {29'h0, last_addr}, m_last);
        msel = 3'($urandom_range(0, 7));
        #1;
        chk($sformatf("%s mux sel%0d", ctx, msel), {16'h0, mux_out},
            m_val[msel]);
    endtask

    // called at a negedge; leaves the bench at the next negedge
    task automatic step(input string ctx, input bit en, input int unsigned a,
                        input int unsigned o, input int unsigned d);
        wr_en   = en;
        wr_addr = 3'(a);
        op      = 2'(o);
        wr_data = 16'(d);
        @(posedge clock);
        model_op(en, a, o, d);
        @(negedge clock);
        check_all(ctx);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        msel    = 3'd0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        op      = 2'd0;
        wr_data = 16'd0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all("reset");
        reset = 1'b0;

        step("ld3", 1, 3, 1, 16'hA5A5);
        chk("ld3 r3 const", {16'h0, r[3]}, 32'hA5A5);
        step("ld7", 1, 7, 1, 16'h1234);
        chk("ld7 r7 const", {16'h0, r[7]}, 32'h1234);
        chk("ld7 ack const", {31'h0, wr_ack}, 32'h1);
        chk("ld7 last const", {29'h0, last_addr}, 32'h7);
        step("idle", 0, 0, 0, 0);

        step("ld5", 1, 5, 1, 16'hFFFE);
        step("inc1", 1, 5, 2, 0);
        chk("inc1 ovf const", {24'h0, ovf}, 32'h00);
        step("inc2", 1, 5, 2, 0);
        chk("inc2 r5 const", {16'h0, r[5]}, 32'h0000);
        chk("inc2 ovf const", {24'h0, ovf}, 32'h20);
        step("inc3", 1, 5, 2, 0);
        chk("inc3 r5 const", {16'h0, r[5]}, 32'h0001);
        step("ld5b", 1, 5, 1, 16'h0042);
        chk("ld5b ovf const", {24'h0, ovf}, 32'h20);
        step("clr5", 1, 5, 3, 0);
        chk("clr5 ovf const", {24'h0, ovf}, 32'h00);

        for (int a = 0; a < 8; a++)
            step($sformatf("noen%0d", a), 0, a, 1, 16'hFFFF);
        for (int a = 0; a < 8; a++)
            step($sformatf("nop%0d", a), 1, a, 0, 16'hFFFF);

        // X on idle inputs
        wr_en   = 1'b0;
        wr_addr = 3'bx;
        op      = 2'bx;
        wr_data = 16'hxxxx;
        @(posedge clock);
        model_op(0, 0, 0, 0);
        @(negedge clock);
        check_all("xidle");

        // CLR then INC-wrap on consecutive cycles
        step("ld2", 1, 2, 1, 16'hFFFF);
        step("inc2w", 1, 2, 2, 0);
        step("reld2", 1, 2, 1, 16'hFFFF);
        step("clr2", 1, 2, 3, 0);
        chk("clr2 ovf2", {31'h0, ovf[2]}, 32'h0);
        step("ld2c", 1, 2, 1, 16'hFFFF);
        step("inc2c", 1, 2, 2, 0);
        chk("inc2c ovf2", {31'h0, ovf[2]}, 32'h1);

        // mid-stream asynchronous reset with an op presented
        step("ld1", 1, 1, 1, 16'h5555);
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 3'd1;
        op      = 2'd1;
        wr_data = 16'h7777;
        #1;
        model_reset();
        check_all("arst");
        @(posedge clock);
        @(negedge clock);
        check_all("arst_edge");
        reset = 1'b0;

        for (int n = 0; n < 2000; n++) begin
            bit          en;
            int unsigned a, o, d;
            en = ($urandom_range(0, 7) != 0);
            a  = $urandom_range(0, 7);
            o  = $urandom_range(0, 3);
            // bias data toward the wrap boundary
            d  = ($urandom_range(0, 3) == 0) ? 16'hFFFF - $urandom_range(0, 2)
                                              : $urandom_range(0, 65535);
            step("rnd", en, a, o, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_bank8x16.md
# register_bank8x16

Eight-entry, 16-bit general-purpose register bank that drives the eight data inputs (m0..m7) of the datapath's 8-to-1 16-bit operand multiplexer. It has one write port with per-entry load, increment and clear operations, a sticky per-entry increment-overflow flag, and a one-cycle write acknowledge. All eight entries are presented in parallel and continuously, so the downstream mux performs the read selection.

## Interface
- WIDTH, 16, data width of each entry. Must match the mux data width.
- DEPTH, 8, number of entries. Fixed at 8 to match the 3-bit mux select.
- ADDR_W, 3, write address width, equal to log2(DEPTH).
- clock  input  1  Single system clock. All state updates on the rising edge.
- reset  input  1  Asynchronous, active-high reset.
- wr_en  input  1  Qualifies op/wr_addr/wr_data for this cycle.
- wr_addr  input  ADDR_W  Target entry.
- op  input  2  00 NOP, 01 LOAD, 10 INC, 11 CLR.
- wr_data  input  WIDTH  Data for LOAD. Ignored for all other ops.
- r0..r7  output  WIDTH each  Registered entry contents. Connect to mux m0..m7.
- ovf  output  DEPTH  Sticky overflow flags. Bit i belongs to entry i.
- wr_ack  output  1  Registered pulse, high for one cycle after any accepted non-NOP op.
- last_addr  output  ADDR_W  Address of the most recent accepted non-NOP op.

## Operation
- An op is accepted on a rising edge when wr_en=1 and op≠NOP. Only entry wr_addr changes; all other entries hold.
- LOAD: entry ← wr_data. The entry's ovf bit is unchanged.
- INC: entry ← (entry + 1) mod 2^WIDTH.
  - If the entry was 16'hFFFF, it becomes 16'h0000 and its ovf bit is set.
  - The ovf bit otherwise holds.
- CLR: entry ← 0 and its ovf bit ← 0.
- NOP, or wr_en=0: no state change, wr_ack ← 0, last_addr holds.
- An accepted op sets wr_ack ← 1 and last_addr ← wr_addr for the following cycle.
  - Back-to-back accepted ops keep wr_ack high continuously.
- There is no internal state machine. Each entry is an independent register with op-decoded next-state logic; the bank is a single write port with no read port.
- Arithmetic is unsigned and truncated to WIDTH bits. No saturation.
- The ovf bits are cleared only by CLR to the same entry or by reset. LOAD does not clear them.

## Timing
- Reset (asynchronous, takes effect immediately regardless of clock):
  - r0..r7 = 0, ovf = 0, wr_ack = 0, last_addr = 0.
  - Deassertion is synchronised externally. The first op is accepted on the first rising edge with reset low.
- Write latency is 1 cycle: the new value appears on rN, ovf, wr_ack and last_addr after the accepting edge.
- Outputs are flop Q outputs only, with no combinational path from inputs to outputs. The downstream mux therefore sees stable operands for the full cycle.
- Reset asserted mid-sequence: any op presented on the same edge is discarded, and all outputs show reset values while reset is high.
- INC of 16'hFFFF followed by INC on the next cycle: 0000 with ovf set, then 0001 with ovf still set.
- A CLR and a subsequent INC-wrap to the same entry on consecutive cycles: ovf goes 0, then 1.
- X on op/wr_addr/wr_data while wr_en=0 must not change state.

## Structure
- Package reg_bank_pkg holds:
  - WIDTH, DEPTH and ADDR_W defaults.
  - The op encoding constants OP_NOP, OP_LOAD, OP_INC and OP_CLR (2-bit typedef reg_op_t).
- Sub-module reg16_cell: one entry plus its ovf bit. Its inputs are clock, reset, sel (wr_en & address decode), op and wr_data; its outputs are q and ovf.
- The top level instantiates reg16_cell DEPTH times and contains the address decoder plus the wr_ack/last_addr flops.

## Test plan
- Reset → all rN=0000, ovf=00, wr_ack=0, last_addr=0. Assert reset mid-stream after loads → outputs zero immediately, without waiting for a clock edge.
- LOAD 16'hA5A5 to addr 3, then LOAD 16'h1234 to addr 7 → r3=A5A5 and r7=1234 one cycle after each edge; other entries 0; wr_ack high for 2 cycles; last_addr goes 3 then 7.
- LOAD FFFE to addr 5, then INC ×3 → r5 = FFFF, 0000, 0001; ovf[5] set from the second INC onward; all other ovf bits 0.
- With ovf[5] set: LOAD 0042 to addr 5 → ovf[5] stays 1. Then CLR addr 5 → r5=0000, ovf[5]=0.
- wr_en=0 with op=LOAD, wr_data=FFFF on every address, and separately wr_en=1 with op=NOP → no entry changes, wr_ack=0, last_addr held.
- Random ops for 2000 cycles checked against a reference model, with rN also routed through the 8-to-1 mux → the mux output equals the model entry for each select value.
